// File: rtl/result_writeback.sv
// Result writeback: masks four adder-stage lane sums to LOG_Q bits, buffers them and writes 64-bit words to BRAM.
// Optional drop counter is enabled by defining RESULT_WB_DROP_CNT_EN.
module result_writeback #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int LOG_Q      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_STEP  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [31:0]                 base_addr,
    input  logic [15:0]                 word_count,
    input  logic                        sum_valid,
    input  logic [DATA_WIDTH*LANES-1:0] sum_data,
    output logic                        sum_ready,
    output logic                        wr_req,
    input  logic                        wr_grant,
    output logic                        wen,
    output logic [31:0]                 addr,
    output logic [DATA_WIDTH*LANES-1:0] wdata,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 drop_cnt
);

    localparam int WORD_W = DATA_WIDTH * LANES;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] LANE_MASK = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - LOG_Q);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [15:0]       accepted;
    logic [15:0]       written;
    logic [15:0]       word_count_r;
    logic [31:0]       addr_r;

    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              start_ok;
    logic [WORD_W-1:0] masked;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign wr_req    = !fifo_empty && ((state == RUN) || (state == DRAIN));
    assign wen       = wr_req && wr_grant;
    assign pop       = wen;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a word.
    assign sum_ready = (state == RUN) && (!fifo_full || pop);
    assign push      = sum_valid && sum_ready;

    assign addr  = addr_r;
    assign wdata = mem[rd_ptr[PTR_W-1:0]];
    assign busy  = (state == RUN) || (state == DRAIN);
    assign done  = (state == DONE);

    always_comb begin
        masked = '0;
        for (int k = 0; k < LANES; k++) begin
            masked[k*DATA_WIDTH +: DATA_WIDTH] = sum_data[k*DATA_WIDTH +: DATA_WIDTH] & LANE_MASK;
        end
    end

    // Storage is cleared on reset so the head word reads as zero before any push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= masked;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            accepted     <= '0;
            written      <= '0;
            word_count_r <= '0;
            addr_r       <= '0;
        end else if (start_ok) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            accepted     <= '0;
            written      <= '0;
            word_count_r <= word_count;
            addr_r       <= base_addr;
            state        <= (word_count == 16'd0) ? DONE : RUN;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + (PTR_W+1)'(1);
                accepted <= accepted + 16'd1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
                written <= written + 16'd1;
                addr_r  <= addr_r + 32'(ADDR_STEP);
            end
            // Transitions fire on the edge that completes the count, so done follows the last write directly.
            case (state)
                RUN: begin
                    if (push && ((accepted + 16'd1) == word_count_r)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && ((written + 16'd1) == word_count_r)) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

`ifdef RESULT_WB_DROP_CNT_EN
    logic [15:0] drop_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_r <= '0;
        end else if (start_ok) begin
            drop_r <= '0;
        end else if ((state == RUN) && sum_valid && !sum_ready && (drop_r != 16'hFFFF)) begin
            drop_r <= drop_r + 16'd1;
        end
    end

    assign drop_cnt = drop_r;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: table-driven single-word vectors plus multi-cycle sequences.
module tb_result_writeback;

    localparam int STEP = 8;
`ifdef RESULT_WB_DROP_CNT_EN
    localparam logic [15:0] EXP_DROP = 16'd2;
`else
    localparam logic [15:0] EXP_DROP = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        sum_valid;
    logic [63:0] sum_data;
    logic        sum_ready;
    logic        wr_req;
    logic        wr_grant;
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] drop_cnt;

    int          compared   = 0;
    int          mismatched = 0;
    int          writes     = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr;

    result_writeback #(
        .DATA_WIDTH(16),
        .LANES(4),
        .LOG_Q(15),
        .FIFO_DEPTH(4),
        .ADDR_STEP(STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .sum_valid(sum_valid),
        .sum_data(sum_data),
        .sum_ready(sum_ready),
        .wr_req(wr_req),
        .wr_grant(wr_grant),
        .wen(wen),
        .addr(addr),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [63:0] data;
        logic [63:0] exp_data;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[4];

    // Reference reduction for LOG_Q = 15: keep the low 15 bits of every 16-bit lane.
    function automatic logic [63:0] maskWord(input logic [63:0] w);
        logic [63:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*16 +: 16] = {1'b0, w[k*16 +: 15]};
        end
        return r;
    endfunction

    function automatic logic [63:0] wordOf(input int i);
        return {16'hF000 + 16'(i), 16'(i), 16'h1234, 16'h8000 | 16'(i)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, then check readiness and any write against the model.
    task automatic applyStimulus(input logic valid, input logic [63:0] data, input logic grant,
                                 input logic exp_ready);
        @(negedge clk);
        start     = 1'b0;
        sum_valid = valid;
        sum_data  = data;
        wr_grant  = grant;
        #1;
        checkOutput("sum_ready", sum_ready, exp_ready);
        if (wen) begin
            writes++;
            if (exp_q.size() == 0) begin
                checkOutput("wen_with_nothing_pending", wen, 0);
            end else begin
                checkOutput("wdata", wdata, exp_q.pop_front());
                checkOutput("addr", addr, exp_addr);
                exp_addr += STEP;
            end
        end
        if (valid && exp_ready) exp_q.push_back(maskWord(data));
    endtask

    task automatic doStart(input logic [31:0] base, input logic [15:0] count);
        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        word_count = count;
        sum_valid  = 1'b0;
        wr_grant   = 1'b0;
        exp_addr   = base;
        exp_q.delete();
        writes     = 0;
    endtask

    task automatic waitDone(input int exp_writes);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
            if (done === 1'b1) break;
        end
        checkOutput("done_reached", done, 1);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("write_count", writes, exp_writes);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sum_ready"}, sum_ready, 0);
        checkOutput({tag, "_wr_req"}, wr_req, 0);
        checkOutput({tag, "_wen"}, wen, 0);
        checkOutput({tag, "_addr"}, addr, 0);
        checkOutput({tag, "_wdata"}, wdata, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_7FFF_7FFF_7FFF, 32'h0000_2008};
        vecs[1] = '{32'h0000_3008, 64'h1234_1234_1234_1234, 64'h1234_1234_1234_1234, 32'h0000_3010};
        vecs[2] = '{32'hFFFF_FFF8, 64'h8000_7FFF_0000_ABCD, 64'h0000_7FFF_0000_2BCD, 32'h0000_0000};
        vecs[3] = '{32'h1234_5678, 64'h0001_8002_4003_C004, 64'h0001_0002_4003_4004, 32'h1234_5680};

        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        sum_valid  = 1'b0;
        sum_data   = '0;
        wr_grant   = 1'b0;
        exp_addr   = '0;
        #2;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic stream of three words with the grant held high.
        doStart(32'h100, 16'd3);
        applyStimulus(1'b1, wordOf(1), 1'b1, 1'b1);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("no_wen_first_cycle", wen, 0);
        applyStimulus(1'b1, wordOf(2), 1'b1, 1'b1);
        checkOutput("basic_wen0", wen, 1);
        applyStimulus(1'b1, wordOf(3), 1'b1, 1'b1);
        checkOutput("basic_wen1", wen, 1);
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("basic_wen2", wen, 1);
        checkOutput("basic_last_addr", addr, 32'h110);
        checkOutput("done_low_on_last_write", done, 0);
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("done_after_last_wen", done, 1);
        checkOutput("basic_writes", writes, 3);

        // Single-word vectors covering lane masking and 32-bit address wrap.
        for (int v = 0; v < 4; v++) begin
            doStart(vecs[v].base, 16'd1);
            applyStimulus(1'b1, vecs[v].data, 1'b1, 1'b1);
            @(negedge clk);
            sum_valid = 1'b0;
            #1;
            checkOutput("vec_wen", wen, 1);
            checkOutput("vec_wdata", wdata, vecs[v].exp_data);
            checkOutput("vec_addr", addr, vecs[v].base);
            @(negedge clk);
            #1;
            checkOutput("vec_done", done, 1);
            checkOutput("vec_next_addr", addr, vecs[v].exp_next);
        end

        // Zero-length transfer completes immediately without writing.
        doStart(32'h500, 16'd0);
        applyStimulus(1'b1, wordOf(9), 1'b1, 1'b0);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_busy", busy, 0);
        checkOutput("zero_addr", addr, 32'h500);
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("zero_writes", writes, 0);

        // Grant withheld: the FIFO fills after four words and the rest are dropped.
        doStart(32'h40, 16'd6);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, wordOf(40 + i), 1'b0, (i < 4));
        end
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
        checkOutput("stall_drop_cnt", drop_cnt, EXP_DROP);
        checkOutput("stall_wr_req", wr_req, 1);
        checkOutput("stall_wen", wen, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 64'd0, 1'b1, 1'b1);
        end
        checkOutput("stall_release_writes", writes, 4);
        checkOutput("stall_not_done", done, 0);
        checkOutput("stall_busy", busy, 1);
        applyStimulus(1'b1, wordOf(50), 1'b1, 1'b1);
        applyStimulus(1'b1, wordOf(51), 1'b1, 1'b1);
        waitDone(6);

        // Full FIFO with simultaneous push and pop keeps one write per cycle.
        doStart(32'h800, 16'd8);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, wordOf(60 + i), 1'b0, 1'b1);
        end
        for (int i = 4; i < 8; i++) begin
            applyStimulus(1'b1, wordOf(60 + i), 1'b1, 1'b1);
            checkOutput("pushpop_wen", wen, 1);
        end
        checkOutput("pushpop_drop_cnt", drop_cnt, 0);
        waitDone(8);

        // Reset in the middle of a transfer, then a clean restart.
        doStart(32'h200, 16'd5);
        applyStimulus(1'b1, wordOf(70), 1'b1, 1'b1);
        applyStimulus(1'b1, wordOf(71), 1'b1, 1'b1);
        applyStimulus(1'b1, wordOf(72), 1'b1, 1'b1);
        checkOutput("pre_reset_writes", writes, 2);
        @(negedge clk);
        sum_valid = 1'b0;
        rst       = 1'b1;
        #1;
        checkResetOutputs("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, wordOf(80 + i), 1'b1, 1'b0);
        end
        checkOutput("post_reset_writes", writes, 2);
        doStart(32'h300, 16'd2);
        applyStimulus(1'b1, wordOf(90), 1'b1, 1'b1);
        applyStimulus(1'b1, wordOf(91), 1'b1, 1'b1);
        checkOutput("restart_first_addr", addr, 32'h300);
        waitDone(2);
        checkOutput("restart_final_addr", addr, 32'h310);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/result_writeback.md
# result_writeback

Downstream of the multiplier datapath. Collects the four 16-bit lane sums that the adder stage produces on each valid cycle, reduces each lane modulo 2^LOG_Q, buffers them in a small FIFO and writes them as 64-bit words to a shared single-port BRAM. Writes go to consecutive addresses, and each write waits for an arbiter grant. Raises `done` once the programmed word count has been committed.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of one lane.
- `LANES`, 4: lanes per word; word width is `DATA_WIDTH*LANES` = 64.
- `LOG_Q`, 16: modulus exponent; each lane is masked to its low `LOG_Q` bits (Frodo: 15 or 16).
- `FIFO_DEPTH`, 4: buffer entries; power of two, ≥2.
- `ADDR_STEP`, 8: byte-address increment per written word.

Ports:
- `clk`, in, 1: clock. Every flop rises on the `clk` posedge; the design has one clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: one-cycle pulse that captures `base_addr` and `word_count`. Ignored unless in IDLE or DONE.
- `base_addr`, in, 32: byte address of the first word.
- `word_count`, in, 16: number of words to write. 0 is legal.
- `sum_valid`, in, 1: `sum_data` is valid this cycle.
- `sum_data`, in, 64: lane k sits at bits [16k+15:16k].
- `sum_ready`, out, 1: FIFO not full and state is RUN.
- `wr_req`, out, 1: requests the BRAM port.
- `wr_grant`, in, 1: the arbiter grants the port for this cycle.
- `wen`, out, 1: write enable, equal to `wr_req & wr_grant`.
- `addr`, out, 32: write byte address.
- `wdata`, out, 64: reduced write word.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: level, high in DONE.
- `drop_cnt`, out, 16: count of dropped input words (see Configuration).

## Operation
States:
- IDLE → RUN on `start`, if `word_count` ≠ 0.
- IDLE → DONE on `start`, if `word_count` = 0.
- RUN → DRAIN once `accepted` = `word_count`.
- DRAIN → DONE once the FIFO is empty and `written` = `word_count`.
- DONE → RUN or DONE on a new `start`, with the same rule as IDLE.

Datapath rules:
- On `start`, `accepted`, `written` and the FIFO pointers clear, and `base_addr` is loaded into `addr`.
- An input word is accepted when `sum_valid & sum_ready`. Each lane is masked to `LOG_Q` bits, with upper bits zeroed, before it enters the FIFO. Lane order is preserved.
- `sum_valid` while `sum_ready`=0 drops the word and never stalls the source, because the systolic array cannot be backpressured. In DRAIN and IDLE, `sum_valid` is ignored and nothing is counted.
- `wr_req` = FIFO not empty and state is RUN or DRAIN. `wdata` is always the FIFO head.
- On `wen`: pop the head, `written`++, and `addr` += `ADDR_STEP` (32-bit wrap).
- Simultaneous push and pop when the FIFO is full is legal: occupancy is unchanged and `sum_ready` stays 1 through that cycle, because readiness is computed as not full or popping.
- Counters are 16 bit; `word_count` ≤ 65535.
- Reset mid-operation: all state returns to IDLE, the FIFO contents are discarded, and no further `wen` is issued.

## Timing
- Reset values: `sum_ready`=0, `wr_req`=0, `wen`=0, `addr`=0, `wdata`=0, `busy`=0, `done`=0, `drop_cnt`=0.
- Input-to-write latency is one cycle: a word accepted at edge n gives `wr_req`=1 from cycle n+1. If granted in that cycle, `wen` is asserted in that same cycle.
- Sustained throughput is one word per cycle while `wr_grant` is held high.
- `done` rises the cycle after the final `wen`. With `word_count`=0, `done` rises the cycle after `start`.
- `busy` is high from the cycle after `start` until `done` rises.
- `wen`, `addr` and `wdata` are valid in the same cycle and are sampled by the BRAM at the next edge.

## Configuration
- With `RESULT_WB_DROP_CNT_EN` defined: `drop_cnt` increments, saturating at 0xFFFF, on every `sum_valid & ~sum_ready` cycle in RUN. It clears on `start` and on reset.
- Without it: `drop_cnt` is tied to 0 and no counter logic is synthesised.

## Test plan
- **Basic stream.** `base_addr`=0x100, `word_count`=3, three consecutive valid words, `wr_grant`=1 → `wen` at addrs 0x100/0x108/0x110 in three consecutive cycles; `done` the cycle after the third write.
- **Modulus masking.** `LOG_Q`=15, lane value 0xFFFF → written lane 0x7FFF. Value 0x1234 is unchanged.
- **Grant stall.** `wr_grant`=0 while 6 words arrive with `FIFO_DEPTH`=4 → `sum_ready` drops after 4 words. With the macro defined, `drop_cnt`=2. Releasing the grant writes exactly 4 words.
- **Zero length.** `start` with `word_count`=0 → `done`=1 next cycle and no `wen`.
- **Full FIFO push/pop.** FIFO full, `wr_grant`=1, continuous `sum_valid` → one write per cycle, `drop_cnt` stays 0, and word order is preserved.
- **Reset mid-run.** Assert `rst` after 2 of 5 writes → all outputs at reset values immediately. A new `start` begins cleanly from `base_addr`.
